// File: rtl/icap_stream_arb.sv
// Round-robin arbiter that hands the single ICAP configuration stream to one
// AXI4-Stream requester per bitstream, forwarding words through a one-deep slice.
module icap_stream_arb #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [32*NUM_REQ-1:0]   S_AXIS_TDATA,
    input  logic [NUM_REQ-1:0]      S_AXIS_TVALID,
    input  logic [NUM_REQ-1:0]      S_AXIS_TLAST,
    output logic [NUM_REQ-1:0]      S_AXIS_TREADY,
    output logic [31:0]             M_AXIS_TDATA,
    output logic                    M_AXIS_TVALID,
    output logic                    M_AXIS_TLAST,
    input  logic                    M_AXIS_TREADY,
    output logic [NUM_REQ-1:0]      GRANT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ABORT,
    output logic [31:0]             WORD_COUNT
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] RR_RESET   = PW'(NUM_REQ - 1);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [31:0]          wcnt_q, wcnt_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic [31:0]          tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;

    logic [31:0]          own_data_vec [NUM_REQ];
    logic [31:0]          owner_data;
    logic                 owner_valid;
    logic                 owner_last;
    logic                 out_ready;
    logic                 beat;
    logic                 done_w;
    logic                 abort_w;
    logic                 win_found;
    logic [PW-1:0]        win_idx;

    // Owner mux: grant is one-hot, so masking and OR-ing selects the owner's word.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_own
            assign own_data_vec[gi] = grant_q[gi] ? S_AXIS_TDATA[32*gi +: 32] : 32'd0;
        end
    endgenerate

    always_comb begin
        owner_data = 32'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            owner_data = owner_data | own_data_vec[j];
        end
    end

    assign owner_valid = |(grant_q & S_AXIS_TVALID);
    assign owner_last  = |(grant_q & S_AXIS_TLAST);
    assign out_ready   = !tvalid_q || M_AXIS_TREADY;
    assign beat        = (state_q == ST_XFER) && owner_valid && out_ready;
    assign done_w      = beat && owner_last;
    assign abort_w     = (TIMEOUT > 0) && (state_q == ST_XFER) && !beat && (stall_q == STALL_LAST);

    // Search upward from rr_ptr+1 so the most recent owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && (j == (int'(rr_ptr_q) + k) % NUM_REQ) && S_AXIS_TVALID[j]) begin
                    win_found = 1'b1;
                    win_idx   = PW'(j);
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_found) state_d = ST_XFER;
            ST_XFER: if (done_w || abort_w) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY          = (state_q == ST_XFER);
        DONE          = done_w;
        ABORT         = abort_w;
        S_AXIS_TREADY = ((state_q == ST_XFER) && out_ready) ? grant_q : '0;
    end

    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        wcnt_d   = wcnt_q;
        stall_d  = stall_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;

        if (state_q == ST_IDLE) begin
            if (win_found) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    grant_d[j] = (PW'(j) == win_idx);
                end
                rr_ptr_d = win_idx;
                wcnt_d   = 32'd0;
                stall_d  = '0;
            end
        end else begin
            if (beat) begin
                wcnt_d  = (wcnt_q == 32'hFFFF_FFFF) ? wcnt_q : wcnt_q + 32'd1;
                stall_d = '0;
            end else if (TIMEOUT > 0 && !abort_w) begin
                stall_d = stall_q + SW'(1);
            end
            if (done_w || abort_w) begin
                grant_d = '0;
            end
        end

        // The slice drains regardless of state so a held beat survives DONE/ABORT.
        if (beat) begin
            tdata_d  = owner_data;
            tlast_d  = owner_last;
            tvalid_d = 1'b1;
        end else if (M_AXIS_TREADY) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            grant_q  <= '0;
            rr_ptr_q <= RR_RESET;
            wcnt_q   <= 32'd0;
            stall_q  <= '0;
            tdata_q  <= 32'd0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wcnt_q   <= wcnt_d;
            stall_q  <= stall_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign GRANT         = grant_q;
    assign WORD_COUNT    = wcnt_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TVALID = tvalid_q;

endmodule

// File: tb/tb_icap_stream_arb.sv
// Directed bench for icap_stream_arb: two behavioural stream sources, an output
// monitor, and one task per scenario with inline expected-value comparisons.
module tb_icap_stream_arb;

    localparam int NR = 2;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [32*NR-1:0]  S_AXIS_TDATA;
    logic [NR-1:0]     S_AXIS_TVALID;
    logic [NR-1:0]     S_AXIS_TLAST;
    logic [NR-1:0]     S_AXIS_TREADY;
    logic [31:0]       M_AXIS_TDATA;
    logic              M_AXIS_TVALID;
    logic              M_AXIS_TLAST;
    logic              M_AXIS_TREADY;
    logic [NR-1:0]     GRANT;
    logic              BUSY;
    logic              DONE;
    logic              ABORT;
    logic [31:0]       WORD_COUNT;

    always #5 clk = ~clk;

    icap_stream_arb #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .GRANT         (GRANT),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ABORT         (ABORT),
        .WORD_COUNT    (WORD_COUNT)
    );

    int pass_cnt;
    int total_cnt;
    int cyc;

    // Source model state
    int          s_nw   [NR];
    int          s_nbs  [NR];
    int          s_pos  [NR];
    int          s_stop [NR];
    int          s_tot  [NR];
    logic [31:0] s_data [NR];
    logic        s_halt [NR];
    logic        toggle_rdy;

    // Monitor records
    logic [31:0] out_data [$];
    logic        out_last [$];
    int          out_cyc  [$];
    int          in_cyc   [$];
    logic [NR-1:0] grant_seq [$];
    int          acc_cnt [NR];
    int          last_in_cyc [NR];
    int          done_cnt;
    int          abort_cnt;
    int          abort_cyc;
    int          viol;
    logic [31:0] abort_wc;
    logic [NR-1:0] grant_after_abort;
    logic [NR-1:0] prev_grant;
    logic        prev_abort;

    task automatic cfg_src(input int i, input logic [31:0] base, input int nw, input int nbs, input int stop);
        s_data[i] = base;
        s_nw[i]   = nw;
        s_nbs[i]  = nbs;
        s_pos[i]  = 0;
        s_stop[i] = stop;
        s_tot[i]  = 0;
        s_halt[i] = 1'b0;
    endtask

    task automatic clear_mon();
        out_data.delete();
        out_last.delete();
        out_cyc.delete();
        in_cyc.delete();
        grant_seq.delete();
        for (int i = 0; i < NR; i++) begin
            acc_cnt[i]     = 0;
            last_in_cyc[i] = 0;
        end
        done_cnt          = 0;
        abort_cnt         = 0;
        abort_cyc         = 0;
        viol              = 0;
        abort_wc          = 32'hFFFF_FFFF;
        grant_after_abort = '1;
        prev_grant        = '0;
        prev_abort        = 1'b0;
    endtask

    task automatic driver_loop();
        logic [NR-1:0] acc;
        forever begin
            @(negedge clk);
            acc = S_AXIS_TVALID & S_AXIS_TREADY;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) begin
                    s_data[i] = s_data[i] + 32'd1;
                    s_pos[i]  = s_pos[i] + 1;
                    s_tot[i]  = s_tot[i] + 1;
                    if (s_pos[i] == s_nw[i]) begin
                        s_pos[i] = 0;
                        s_nbs[i] = s_nbs[i] - 1;
                    end
                    if (s_tot[i] == s_stop[i]) s_halt[i] = 1'b1;
                end
            end
            if (toggle_rdy) M_AXIS_TREADY = ~M_AXIS_TREADY;
            for (int i = 0; i < NR; i++) begin
                S_AXIS_TVALID[i]          = (s_nbs[i] > 0) && !s_halt[i];
                S_AXIS_TDATA[32*i +: 32]  = s_data[i];
                S_AXIS_TLAST[i]           = (s_pos[i] == s_nw[i] - 1);
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (rst_n) begin
                for (int i = 0; i < NR; i++) begin
                    if (S_AXIS_TVALID[i] && S_AXIS_TREADY[i]) begin
                        in_cyc.push_back(cyc);
                        acc_cnt[i]     = acc_cnt[i] + 1;
                        last_in_cyc[i] = cyc;
                    end
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    out_data.push_back(M_AXIS_TDATA);
                    out_last.push_back(M_AXIS_TLAST);
                    out_cyc.push_back(cyc);
                end
                if (M_AXIS_TVALID && !M_AXIS_TREADY && (|S_AXIS_TREADY)) viol = viol + 1;
                if (DONE) done_cnt = done_cnt + 1;
                if (prev_abort) grant_after_abort = GRANT;
                if (ABORT) begin
                    abort_cnt = abort_cnt + 1;
                    abort_cyc = cyc;
                    abort_wc  = WORD_COUNT;
                end
                prev_abort = ABORT;
                if (GRANT != prev_grant && GRANT != '0) grant_seq.push_back(GRANT);
                prev_grant = GRANT;
            end
        end
    endtask

    task automatic wait_done(input int max, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < max && !ok; c++) begin
            @(negedge clk);
            #1;
            if (((s_nbs[0] == 0) || s_halt[0]) && ((s_nbs[1] == 0) || s_halt[1]) && !BUSY && !M_AXIS_TVALID)
                ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({GRANT, BUSY, DONE, ABORT, M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY} !== '0)
            $display("FAIL reset_ctrl got %b want 0", {GRANT, BUSY, DONE, ABORT, M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY});
        else pass_cnt++;
        total_cnt++;
        if (WORD_COUNT !== 32'd0) $display("FAIL reset_wcount got %h want 0", WORD_COUNT);
        else pass_cnt++;
        total_cnt++;
        if (M_AXIS_TDATA !== 32'd0) $display("FAIL reset_tdata got %h want 0", M_AXIS_TDATA);
        else pass_cnt++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic ok;
        logic [7:0] lastv;
        int lat_bad;
        logic [31:0] got;
        clear_mon();
        M_AXIS_TREADY = 1'b1;
        cfg_src(0, 32'h0000_0001, 8, 1, -1);
        wait_done(100, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL single_finish got %b want 1", ok);
        else pass_cnt++;
        total_cnt++;
        if (out_data.size() != 8) $display("FAIL single_count got %0d want 8", out_data.size());
        else pass_cnt++;
        lastv = '0;
        lat_bad = 0;
        for (int k = 0; k < 8; k++) begin
            got = (k < out_data.size()) ? out_data[k] : 32'hDEAD_BEEF;
            total_cnt++;
            if (got !== 32'(k + 1)) $display("FAIL single_word%0d got %h want %h", k, got, 32'(k + 1));
            else pass_cnt++;
            if (k < out_last.size()) lastv[k] = out_last[k];
            if (k >= out_cyc.size() || k >= in_cyc.size() || out_cyc[k] - in_cyc[k] != 1) lat_bad++;
        end
        total_cnt++;
        if (lastv !== 8'h80) $display("FAIL single_tlast got %b want 10000000", lastv);
        else pass_cnt++;
        total_cnt++;
        if (lat_bad != 0) $display("FAIL single_latency got %0d late beats want 0", lat_bad);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL single_done got %0d want 1", done_cnt);
        else pass_cnt++;
        total_cnt++;
        if (WORD_COUNT !== 32'd8) $display("FAIL single_wcount got %0d want 8", WORD_COUNT);
        else pass_cnt++;
        total_cnt++;
        if (grant_seq.size() != 1 || grant_seq[0] !== 2'b01 || GRANT !== 2'b00)
            $display("FAIL single_grant got n=%0d now=%b want one 01 then 00", grant_seq.size(), GRANT);
        else pass_cnt++;
        $display("test_single done");
    endtask

    task automatic test_two_sources();
        logic ok;
        logic [7:0] lastv;
        logic [31:0] exp, got;
        rst_n = 1'b0;
        clear_mon();
        cfg_src(0, 32'h0000_0100, 4, 1, -1);
        cfg_src(1, 32'h0000_0200, 4, 1, -1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_done(100, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL two_finish got %b want 1", ok);
        else pass_cnt++;
        total_cnt++;
        if (out_data.size() != 8) $display("FAIL two_count got %0d want 8", out_data.size());
        else pass_cnt++;
        lastv = '0;
        for (int k = 0; k < 8; k++) begin
            exp = (k < 4) ? 32'h100 + 32'(k) : 32'h200 + 32'(k - 4);
            got = (k < out_data.size()) ? out_data[k] : 32'hDEAD_BEEF;
            total_cnt++;
            if (got !== exp) $display("FAIL two_word%0d got %h want %h", k, got, exp);
            else pass_cnt++;
            if (k < out_last.size()) lastv[k] = out_last[k];
        end
        total_cnt++;
        if (lastv !== 8'h88) $display("FAIL two_tlast got %b want 10001000", lastv);
        else pass_cnt++;
        total_cnt++;
        if (out_cyc.size() < 5 || out_cyc[4] - out_cyc[3] != 2)
            $display("FAIL two_bubble got gap %0d want 2", (out_cyc.size() < 5) ? -1 : out_cyc[4] - out_cyc[3]);
        else pass_cnt++;
        total_cnt++;
        if (grant_seq.size() != 2 || grant_seq[0] !== 2'b01 || grant_seq[1] !== 2'b10)
            $display("FAIL two_grant_order got n=%0d first=%b want 01,10", grant_seq.size(),
                     (grant_seq.size() > 0) ? grant_seq[0] : 2'bxx);
        else pass_cnt++;
        $display("test_two_sources done");
    endtask

    task automatic test_alternate();
        logic ok;
        logic [NR-1:0] exp_g;
        logic [31:0] exp, got;
        int k;
        clear_mon();
        cfg_src(0, 32'h0000_0300, 2, 3, -1);
        cfg_src(1, 32'h0000_0380, 2, 3, -1);
        wait_done(200, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL alt_finish got %b want 1", ok);
        else pass_cnt++;
        total_cnt++;
        if (grant_seq.size() != 6) $display("FAIL alt_grant_count got %0d want 6", grant_seq.size());
        else pass_cnt++;
        for (int g = 0; g < 6; g++) begin
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            total_cnt++;
            if (g >= grant_seq.size() || grant_seq[g] !== exp_g)
                $display("FAIL alt_grant%0d got %b want %b", g, (g < grant_seq.size()) ? grant_seq[g] : 2'bxx, exp_g);
            else pass_cnt++;
        end
        k = 0;
        for (int b = 0; b < 3; b++) begin
            for (int o = 0; o < 2; o++) begin
                for (int w = 0; w < 2; w++) begin
                    exp = ((o == 0) ? 32'h300 : 32'h380) + 32'(2 * b + w);
                    got = (k < out_data.size()) ? out_data[k] : 32'hDEAD_BEEF;
                    total_cnt++;
                    if (got !== exp) $display("FAIL alt_word%0d got %h want %h", k, got, exp);
                    else pass_cnt++;
                    k++;
                end
            end
        end
        total_cnt++;
        if (done_cnt != 6) $display("FAIL alt_done got %0d want 6", done_cnt);
        else pass_cnt++;
        $display("test_alternate done");
    endtask

    task automatic test_backpressure();
        logic ok;
        logic [15:0] lastv;
        logic [31:0] got;
        clear_mon();
        toggle_rdy = 1'b1;
        cfg_src(0, 32'h0000_0400, 16, 1, -1);
        wait_done(200, ok);
        toggle_rdy    = 1'b0;
        M_AXIS_TREADY = 1'b1;
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL bp_finish got %b want 1", ok);
        else pass_cnt++;
        total_cnt++;
        if (out_data.size() != 16) $display("FAIL bp_count got %0d want 16", out_data.size());
        else pass_cnt++;
        lastv = '0;
        for (int k = 0; k < 16; k++) begin
            got = (k < out_data.size()) ? out_data[k] : 32'hDEAD_BEEF;
            total_cnt++;
            if (got !== 32'h400 + 32'(k)) $display("FAIL bp_word%0d got %h want %h", k, got, 32'h400 + 32'(k));
            else pass_cnt++;
            if (k < out_last.size()) lastv[k] = out_last[k];
        end
        total_cnt++;
        if (lastv !== 16'h8000) $display("FAIL bp_tlast got %h want 8000", lastv);
        else pass_cnt++;
        total_cnt++;
        if (viol != 0) $display("FAIL bp_ready_when_full got %0d cycles want 0", viol);
        else pass_cnt++;
        $display("test_backpressure done");
    endtask

    task automatic test_timeout();
        logic ok;
        logic [4:0] lastv;
        clear_mon();
        cfg_src(0, 32'h0000_0500, 10, 1, 5);
        cfg_src(1, 32'h0000_0600, 2, 0, -1);
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (acc_cnt[0] == 5) ok = 1'b1;
        end
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL to_five_words got %0d want 5", acc_cnt[0]);
        else pass_cnt++;
        cfg_src(1, 32'h0000_0600, 2, 1, -1);
        wait_done(100, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL to_finish got %b want 1", ok);
        else pass_cnt++;
        total_cnt++;
        if (abort_cnt != 1) $display("FAIL to_abort_count got %0d want 1", abort_cnt);
        else pass_cnt++;
        total_cnt++;
        if (abort_cyc - last_in_cyc[0] != TO)
            $display("FAIL to_abort_delay got %0d want %0d", abort_cyc - last_in_cyc[0], TO);
        else pass_cnt++;
        total_cnt++;
        if (abort_wc !== 32'd5) $display("FAIL to_wcount got %0d want 5", abort_wc);
        else pass_cnt++;
        total_cnt++;
        if (grant_after_abort !== 2'b00) $display("FAIL to_grant_clear got %b want 00", grant_after_abort);
        else pass_cnt++;
        lastv = '1;
        for (int k = 0; k < 5; k++) if (k < out_last.size()) lastv[k] = out_last[k];
        total_cnt++;
        if (out_data.size() != 7 || lastv !== 5'b00000)
            $display("FAIL to_no_tlast got n=%0d last=%b want 7,00000", out_data.size(), lastv);
        else pass_cnt++;
        total_cnt++;
        if (grant_seq.size() != 2 || grant_seq[1] !== 2'b10 || out_data[5] !== 32'h600)
            $display("FAIL to_next_owner got n=%0d want grant 10 with data 600", grant_seq.size());
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL to_done got %0d want 1", done_cnt);
        else pass_cnt++;
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        logic ok;
        clear_mon();
        cfg_src(0, 32'h0000_0700, 8, 1, -1);
        cfg_src(1, 32'h0000_0800, 8, 0, -1);
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (acc_cnt[0] == 3) ok = 1'b1;
        end
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL rm_reach_word3 got %0d want 3", acc_cnt[0]);
        else pass_cnt++;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({GRANT, BUSY, M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY} !== '0)
            $display("FAIL rm_async_ctrl got %b want 0", {GRANT, BUSY, M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY});
        else pass_cnt++;
        total_cnt++;
        if (WORD_COUNT !== 32'd0 || M_AXIS_TDATA !== 32'd0)
            $display("FAIL rm_async_data got wc=%h td=%h want 0,0", WORD_COUNT, M_AXIS_TDATA);
        else pass_cnt++;
        clear_mon();
        cfg_src(0, 32'h0000_0900, 2, 1, -1);
        cfg_src(1, 32'h0000_0A00, 2, 1, -1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_done(100, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL rm_finish got %b want 1", ok);
        else pass_cnt++;
        total_cnt++;
        if (grant_seq.size() != 2 || grant_seq[0] !== 2'b01)
            $display("FAIL rm_first_grant got n=%0d first=%b want 01", grant_seq.size(),
                     (grant_seq.size() > 0) ? grant_seq[0] : 2'bxx);
        else pass_cnt++;
        total_cnt++;
        if (out_data.size() != 4 || out_data[0] !== 32'h900)
            $display("FAIL rm_after_data got n=%0d first=%h want 4,900", out_data.size(),
                     (out_data.size() > 0) ? out_data[0] : 32'hDEAD_BEEF);
        else pass_cnt++;
        $display("test_reset_mid done");
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        toggle_rdy    = 1'b0;
        M_AXIS_TREADY = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        for (int i = 0; i < NR; i++) cfg_src(i, 32'd0, 1, 0, -1);
        clear_mon();
        fork
            driver_loop();
            monitor_loop();
        join_none
        test_reset();
        test_single();
        test_two_sources();
        test_alternate();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/icap_stream_arb.md
# icap_stream_arb

Round-robin arbiter and sequencer that shares the single ICAP configuration stream between up to four partial-bitstream sources (DMA channels, PS loader, scrubber). It grants one AXI4-Stream requester at a time and holds the grant for a whole bitstream until that requester's TLAST. It forwards the words through a one-deep register slice to the ICAP stream sink. A stalled transfer is released by timeout. Status outputs report progress.

## Interface
Parameters:
- NUM_REQ, 2: number of requester streams, legal values 1..4.
- TIMEOUT, 1024: stall cycles in XFER before forced release; 0 disables the timeout.

Ports:
- ACLK  in  1  clock. One clock domain; reset is asynchronous and active-low.
- ARESETN  in  1  reset. Asynchronous assert, active-low.
- S_AXIS_TDATA  in  32*NUM_REQ  requester data; requester i uses bits [32i+31:32i].
- S_AXIS_TVALID  in  NUM_REQ  requester valid.
- S_AXIS_TLAST  in  NUM_REQ  requester end-of-bitstream.
- S_AXIS_TREADY  out  NUM_REQ  requester ready.
- M_AXIS_TDATA  out  32  data to the ICAP stream sink.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TLAST  out  1  output last.
- M_AXIS_TREADY  in  1  sink ready.
- GRANT  out  NUM_REQ  one-hot current owner; all zero when idle.
- BUSY  out  1  high in XFER.
- DONE  out  1  one-cycle pulse when the owner's TLAST beat is accepted.
- ABORT  out  1  one-cycle pulse on timeout release.
- WORD_COUNT  out  32  beats accepted from the current or most recent owner.

## Operation
- Reset values: all outputs 0; rr_ptr = NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE → XFER when any S_AXIS_TVALID is high.
    - Winner is the first valid requester searching upward from rr_ptr+1, mod NUM_REQ.
    - On that edge: GRANT is set, rr_ptr becomes the winner, WORD_COUNT and the stall counter clear.
  - XFER → IDLE on an accepted owner beat with TLAST=1. DONE pulses in the same cycle as the state change.
  - XFER → IDLE when the stall counter reaches TIMEOUT. ABORT pulses; GRANT clears.
- Handshake:
  - out_ready = !M_AXIS_TVALID || M_AXIS_TREADY.
  - S_AXIS_TREADY[i] = (state==XFER) && GRANT[i] && out_ready.
  - S_AXIS_TREADY is 0 for non-owners and in IDLE.
- Output register slice:
  - On an accepted owner beat, TDATA and TLAST load into the slice and M_AXIS_TVALID sets.
  - M_AXIS_TVALID clears on M_AXIS_TREADY when no new beat loads in the same cycle.
  - A simultaneous drain and load keeps M_AXIS_TVALID high with the new data.
  - The slice drains independently of state. A beat still held after DONE or ABORT is delivered unchanged.
  - Data is passed as-is; bit-swapping is done downstream.
- WORD_COUNT: increments on each accepted owner beat, saturates at 0xFFFFFFFF, and holds its value in IDLE until the next grant.
- Stall counter:
  - Increments each XFER cycle with no accepted owner beat, whether owner TVALID is low or output backpressure is applied.
  - Clears on any accepted beat.
  - Width is clog2(TIMEOUT+1).
- Abort: no M_AXIS_TLAST is generated. Software must resync ICAP; the aborted requester re-arbitrates like any other.
- NUM_REQ=1: arbitration is trivial; same state machine.
- Reset mid-transfer: everything returns to reset values immediately and any beat held in the slice is discarded.

## Timing
- Arbitration: 1 cycle. If TVALID rises in cycle n while IDLE, GRANT/BUSY are high in n+1 and the first beat can be accepted in n+1.
- Data latency: a beat accepted in cycle n appears on M_AXIS in n+1.
- Throughput: 1 word/cycle while owner TVALID and M_AXIS_TREADY are both high.
- Inter-bitstream gap: TLAST accepted in n, IDLE in n+1, next owner accepting in n+2. This gives one bubble cycle on M_AXIS.
- Timeout: after the last accepted beat in cycle n (or the grant in cycle n), ABORT pulses at cycle n+TIMEOUT; GRANT is 0 in the following cycle.
- Simultaneous requests at a grant decision: the round-robin order decides; no requester waits more than NUM_REQ-1 bitstreams.

## Test plan
- Single requester 0, 8 words 0x00000001..0x00000008, TLAST on word 8, M_AXIS_TREADY=1 → M_AXIS words identical, each 1 cycle after acceptance, TLAST on word 8, DONE one pulse, WORD_COUNT=8, GRANT=0b01 then 0.
- NUM_REQ=2, both valid at reset release, 4-word bitstreams each → req0 first, then req1 after exactly one M_AXIS bubble; no interleaving; final rr_ptr=1.
- Both continuously requesting 3 bitstreams each → grants alternate 0,1,0,1,0,1.
- M_AXIS_TREADY toggling 1,0,1,0 during a 16-word transfer → no lost or duplicated words, order preserved, S_AXIS_TREADY low whenever the slice is full and not draining.
- TIMEOUT=16, owner stops after 5 words with TVALID low → ABORT pulses 16 cycles after word 5, WORD_COUNT=5, no M_AXIS_TLAST, other requester granted next.
- ARESETN asserted mid-transfer at word 3 → all outputs 0 asynchronously; after release, requester 0 is granted first.
